// File: rtl/mem_read_buffer.sv
// mem_read_buffer: gathers four 64-bit rows from data memory into a
// 16-word buffer once all four cores request a load, then hands each core
// the word picked by its own load address as a one-cycle valid pulse.
module mem_read_buffer #(
  parameter int          WORD_W   = 16,
  parameter logic [3:0]  ROW_BASE = 4'b1000,
  parameter int          TIMEOUT  = 8
) (
  input  logic                clk,
  input  logic                RST_N,
  input  logic                MEMRD_1,
  input  logic                MEMRD_2,
  input  logic                MEMRD_3,
  input  logic                MEMRD_4,
  input  logic [3:0]          LOAD_ADD_1,
  input  logic [3:0]          LOAD_ADD_2,
  input  logic [3:0]          LOAD_ADD_3,
  input  logic [3:0]          LOAD_ADD_4,
  output logic [WORD_W-1:0]   DATAOUT_1,
  output logic [WORD_W-1:0]   DATAOUT_2,
  output logic [WORD_W-1:0]   DATAOUT_3,
  output logic [WORD_W-1:0]   DATAOUT_4,
  output logic                RD_VALID_1,
  output logic                RD_VALID_2,
  output logic                RD_VALID_3,
  output logic                RD_VALID_4,
  output logic                MEM_RD_REQ,
  output logic [3:0]          ROW_ADDR,
  input  logic [4*WORD_W-1:0] FROM_DATA_MEM,
  input  logic                MEM_RD_ACK
);

  localparam int ROW_W = 4 * WORD_W;
  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    RETRY,
    SERVE,
    DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [1:0]        row_cnt_reg, row_cnt_next;
  logic [TMO_W-1:0]  tmo_cnt_reg, tmo_cnt_next;
  logic              req_reg, req_next;
  logic [3:0]        row_addr_reg, row_addr_next;
  logic              rd_valid_reg, rd_valid_next;

  logic [3:0]        memrd_vec;
  logic              all_req;
  logic              any_req;
  logic              capture;
  logic              serve;

  logic [3:0]        load_add_arr [4];
  logic [WORD_W-1:0] buf_word     [16];
  logic [WORD_W-1:0] dout_arr     [4];

  assign memrd_vec = {MEMRD_4, MEMRD_3, MEMRD_2, MEMRD_1};
  assign all_req   = &memrd_vec;
  assign any_req   = |memrd_vec;

  // A row is only written when the fetch is still wanted by every core;
  // an ACK on the same edge as an abort is dropped.
  assign capture = (state_reg == FETCH) && all_req && MEM_RD_ACK;
  assign serve   = (state_reg == SERVE);

  assign load_add_arr[0] = LOAD_ADD_1;
  assign load_add_arr[1] = LOAD_ADD_2;
  assign load_add_arr[2] = LOAD_ADD_3;
  assign load_add_arr[3] = LOAD_ADD_4;

  // FSM and control state register.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= IDLE;
      row_cnt_reg  <= 2'd0;
      tmo_cnt_reg  <= '0;
      req_reg      <= 1'b0;
      row_addr_reg <= 4'd0;
      rd_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      row_cnt_reg  <= row_cnt_next;
      tmo_cnt_reg  <= tmo_cnt_next;
      req_reg      <= req_next;
      row_addr_reg <= row_addr_next;
      rd_valid_reg <= rd_valid_next;
    end
  end

  // Next-state logic: trigger, row sequencing, timeout/retry, abort, serve.
  always_comb begin
    state_next    = state_reg;
    row_cnt_next  = row_cnt_reg;
    tmo_cnt_next  = tmo_cnt_reg;
    req_next      = req_reg;
    row_addr_next = row_addr_reg;
    rd_valid_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (all_req) begin
          state_next    = FETCH;
          row_cnt_next  = 2'd0;
          tmo_cnt_next  = '0;
          req_next      = 1'b1;
          row_addr_next = ROW_BASE;
        end
      end
      FETCH: begin
        if (!all_req) begin
          state_next = IDLE;
          req_next   = 1'b0;
        end else if (MEM_RD_ACK) begin
          if (row_cnt_reg == 2'd3) begin
            state_next = SERVE;
            req_next   = 1'b0;
          end else begin
            row_cnt_next  = row_cnt_reg + 2'd1;
            row_addr_next = row_addr_reg + 4'd1;
            tmo_cnt_next  = '0;
          end
        end else if (tmo_cnt_reg == TMO_W'(TIMEOUT - 1)) begin
          state_next   = RETRY;
          req_next     = 1'b0;
          tmo_cnt_next = '0;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
        end
      end
      RETRY: begin
        // One idle cycle with REQ low, then re-issue the same row.
        if (!all_req) begin
          state_next = IDLE;
          req_next   = 1'b0;
        end else begin
          state_next   = FETCH;
          req_next     = 1'b1;
          tmo_cnt_next = '0;
        end
      end
      SERVE: begin
        state_next    = DONE;
        rd_valid_next = 1'b1;
      end
      DONE: begin
        // Wait for every core to drop its request so held levels do not
        // start another fetch.
        if (!any_req) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  // Word buffer: each word captures its slice of the row whose index
  // matches the current row counter. Row MSBs hold the lowest word.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : gen_word
      logic [WORD_W-1:0] word_reg;

      // Capture this word's slice when its row is acknowledged.
      always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
          word_reg <= '0;
        end else if (capture && (row_cnt_reg == 2'(gi / 4))) begin
          word_reg <= FROM_DATA_MEM[ROW_W-1-(gi%4)*WORD_W -: WORD_W];
        end
      end

      assign buf_word[gi] = word_reg;
    end
  endgenerate

  // Per-core output registers: sampled once on the SERVE exit edge, held after.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gen_port
      logic [WORD_W-1:0] dout_reg;

      // Load the selected word for this core when serving.
      always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
          dout_reg <= '0;
        end else if (serve) begin
          dout_reg <= buf_word[load_add_arr[gi]];
        end
      end

      assign dout_arr[gi] = dout_reg;
    end
  endgenerate

  assign DATAOUT_1  = dout_arr[0];
  assign DATAOUT_2  = dout_arr[1];
  assign DATAOUT_3  = dout_arr[2];
  assign DATAOUT_4  = dout_arr[3];
  assign RD_VALID_1 = rd_valid_reg;
  assign RD_VALID_2 = rd_valid_reg;
  assign RD_VALID_3 = rd_valid_reg;
  assign RD_VALID_4 = rd_valid_reg;
  assign MEM_RD_REQ = req_reg;
  assign ROW_ADDR   = row_addr_reg;

endmodule

// File: tb/tb_mem_read_buffer.sv
// Directed testbench for mem_read_buffer: a behavioural data memory answers
// row requests; a linear sequence of steps checks reset, loads, partial
// requests, timeout/retry, abort, hold-off and reset during a fetch.
module tb_mem_read_buffer;

  logic        clk;
  logic        rst_n;
  logic [3:0]  memrd;
  logic [3:0]  load_add [4];
  logic [15:0] dout1, dout2, dout3, dout4;
  logic        rv1, rv2, rv3, rv4;
  logic        req;
  logic [3:0]  row_addr;
  logic [63:0] mem_data;
  logic        mem_ack;

  logic [15:0] mem_words [16];
  int          withhold_left;
  logic [3:0]  withhold_row;

  int checks;
  int errors;

  mem_read_buffer #(.WORD_W(16), .ROW_BASE(4'b1000), .TIMEOUT(8)) dut (
    .clk           (clk),
    .RST_N         (rst_n),
    .MEMRD_1       (memrd[0]),
    .MEMRD_2       (memrd[1]),
    .MEMRD_3       (memrd[2]),
    .MEMRD_4       (memrd[3]),
    .LOAD_ADD_1    (load_add[0]),
    .LOAD_ADD_2    (load_add[1]),
    .LOAD_ADD_3    (load_add[2]),
    .LOAD_ADD_4    (load_add[3]),
    .DATAOUT_1     (dout1),
    .DATAOUT_2     (dout2),
    .DATAOUT_3     (dout3),
    .DATAOUT_4     (dout4),
    .RD_VALID_1    (rv1),
    .RD_VALID_2    (rv2),
    .RD_VALID_3    (rv3),
    .RD_VALID_4    (rv4),
    .MEM_RD_REQ    (req),
    .ROW_ADDR      (row_addr),
    .FROM_DATA_MEM (mem_data),
    .MEM_RD_ACK    (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data memory: acknowledges a raised request in the same
  // cycle, optionally withholding ACK for a chosen row a number of times.
  always @(negedge clk) begin
    if (req && (withhold_left > 0) && (row_addr == withhold_row)) begin
      mem_ack = 1'b0;
      withhold_left = withhold_left - 1;
    end else if (req) begin
      mem_ack  = 1'b1;
      mem_data = {mem_words[{row_addr[1:0], 2'd0}], mem_words[{row_addr[1:0], 2'd1}],
                  mem_words[{row_addr[1:0], 2'd2}], mem_words[{row_addr[1:0], 2'd3}]};
    end else begin
      mem_ack = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_douts(input string tag, input logic [15:0] e1, input logic [15:0] e2,
                             input logic [15:0] e3, input logic [15:0] e4);
    check({tag, "_dout1"}, 64'(dout1), 64'(e1));
    check({tag, "_dout2"}, 64'(dout2), 64'(e2));
    check({tag, "_dout3"}, 64'(dout3), 64'(e3));
    check({tag, "_dout4"}, 64'(dout4), 64'(e4));
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    memrd         = 4'b0000;
    mem_ack       = 1'b0;
    mem_data      = 64'd0;
    withhold_left = 0;
    withhold_row  = 4'd0;
    for (int i = 0; i < 4; i++) load_add[i] = 4'd0;
    for (int i = 0; i < 16; i++) mem_words[i] = 16'(i);

    // Reset state
    tick();
    tick();
    check("rst_req", 64'(req), 64'd0);
    check("rst_row", 64'(row_addr), 64'd0);
    check("rst_valid", 64'({rv4, rv3, rv2, rv1}), 64'd0);
    check_douts("rst", 16'h0, 16'h0, 16'h0, 16'h0);
    rst_n = 1'b1;
    tick();

    // Basic load: words 0,5,10,15; rows acked back to back
    load_add[0] = 4'd0; load_add[1] = 4'd5; load_add[2] = 4'd10; load_add[3] = 4'd15;
    memrd = 4'b1111;
    tick();
    check("basic_req_t0", 64'(req), 64'd1);
    check("basic_row_t0", 64'(row_addr), 64'h8);
    check("basic_valid_t0", 64'(rv1), 64'd0);
    tick();
    check("basic_row_t1", 64'(row_addr), 64'h9);
    tick();
    check("basic_row_t2", 64'(row_addr), 64'hA);
    tick();
    check("basic_row_t3", 64'(row_addr), 64'hB);
    check("basic_req_t3", 64'(req), 64'd1);
    tick();
    check("basic_req_t4", 64'(req), 64'd0);
    check("basic_valid_t4", 64'({rv4, rv3, rv2, rv1}), 64'd0);
    tick();
    check("basic_valid_t5", 64'({rv4, rv3, rv2, rv1}), 64'hF);
    check_douts("basic", 16'h0000, 16'h0005, 16'h000A, 16'h000F);
    tick();
    check("basic_valid_t6", 64'({rv4, rv3, rv2, rv1}), 64'd0);
    check_douts("basic_hold", 16'h0000, 16'h0005, 16'h000A, 16'h000F);

    // Held requests after RD_VALID must not start another fetch
    for (int i = 0; i < 8; i++) begin
      tick();
      check("hold_req", 64'(req), 64'd0);
      check("hold_valid", 64'(rv1), 64'd0);
    end
    memrd = 4'b0000;
    tick();
    tick();

    // Partial request (core 4 idle) for 20 cycles, then timeout on row 9
    load_add[0] = 4'd4; load_add[1] = 4'd9; load_add[2] = 4'd14; load_add[3] = 4'd3;
    memrd = 4'b0111;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("partial_req", 64'(req), 64'd0);
    end
    withhold_row  = 4'h9;
    withhold_left = 8;
    memrd = 4'b1111;
    tick();
    check("partial_go_req", 64'(req), 64'd1);
    check("partial_go_row", 64'(row_addr), 64'h8);
    tick();
    check("tmo_row_first", 64'(row_addr), 64'h9);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("tmo_req_held", 64'(req), 64'd1);
      check("tmo_row_held", 64'(row_addr), 64'h9);
    end
    tick();
    check("tmo_req_drop", 64'(req), 64'd0);
    tick();
    check("tmo_req_again", 64'(req), 64'd1);
    check("tmo_row_again", 64'(row_addr), 64'h9);
    tick();
    tick();
    tick();
    check("tmo_valid_early", 64'(rv1), 64'd0);
    tick();
    check("tmo_valid", 64'({rv4, rv3, rv2, rv1}), 64'hF);
    check_douts("tmo", 16'h0004, 16'h0009, 16'h000E, 16'h0003);
    memrd = 4'b0000;
    tick();
    tick();

    // Abort: drop MEMRD_2 while row 10 is being fetched
    memrd = 4'b1111;
    begin
      int n;
      n = 0;
      tick();
      while (!(req && row_addr == 4'hA) && n < 10) begin
        tick();
        n++;
      end
      check("abort_reached_row10", 64'(req && row_addr == 4'hA), 64'd1);
    end
    memrd = 4'b1101;
    tick();
    check("abort_req", 64'(req), 64'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("abort_no_valid", 64'(rv2), 64'd0);
      check("abort_no_req", 64'(req), 64'd0);
    end
    check_douts("abort_keep", 16'h0004, 16'h0009, 16'h000E, 16'h0003);
    memrd = 4'b0000;
    tick();

    // Same index on every port
    mem_words[7] = 16'hBEEF;
    for (int i = 0; i < 4; i++) load_add[i] = 4'd7;
    memrd = 4'b1111;
    for (int i = 0; i < 5; i++) tick();
    check("same_valid_early", 64'(rv3), 64'd0);
    tick();
    check("same_valid", 64'({rv4, rv3, rv2, rv1}), 64'hF);
    check_douts("same", 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF);
    memrd = 4'b0000;
    tick();
    tick();

    // Reset asserted in the middle of a fetch
    memrd = 4'b1111;
    tick();
    tick();
    check("midrst_pre_req", 64'(req), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_req", 64'(req), 64'd0);
    check("midrst_row", 64'(row_addr), 64'd0);
    check("midrst_valid", 64'({rv4, rv3, rv2, rv1}), 64'd0);
    check_douts("midrst", 16'h0, 16'h0, 16'h0, 16'h0);
    memrd = 4'b0000;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("postrst_no_req", 64'(req), 64'd0);
    end
    memrd = 4'b1111;
    tick();
    check("postrst_req", 64'(req), 64'd1);
    check("postrst_row", 64'(row_addr), 64'h8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
